// File: rtl/hdmi_island_scheduler.sv
// Per-line HDMI blanking sequencer and packet-slot arbiter (preamble, guard bands, 32-cycle slots).
// Optional HDMI_INFOFRAME_AUTO_EN: vSync rising edge auto-requests AVI and audio infoframes once per frame.
module hdmi_island_scheduler #(
    parameter int DISPLAY_WIDTH = 720,
    parameter int FULL_WIDTH    = 858,
    parameter int MAX_PACKETS   = 2,
    parameter int DATA_START    = DISPLAY_WIDTH + 4,
    parameter int CTL_END       = FULL_WIDTH - 10
) (
    input  logic       pixclk,
    input  logic       reset_n,
    input  logic [9:0] CounterX,
    input  logic       vSync,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       null_slot,
    output logic [3:0] preamble,
    output logic       terc_data,
    output logic       data_gb,
    output logic       video_gb,
    output logic [4:0] pkt_offset,
    output logic       first_pkt,
    output logic       hdr_ecc_en,
    output logic       sub_ecc_en
);

    typedef enum logic [2:0] {
        S_IDLE, S_DPRE, S_LGB, S_PKT, S_TGB, S_CTL, S_VPRE, S_VGB
    } state_t;

    state_t     r_state, w_state_n;
    logic [4:0] r_cnt, w_cnt_n;
    logic [1:0] r_slot, w_slot_n;
    logic [1:0] r_n, w_n_n;
    logic       r_rr;
    logic [3:0] w_req, w_arb_grant, w_grant_n;
    logic [2:0] w_pop;
    logic [1:0] w_n_new;
    logic       w_arb, w_more;

`ifdef HDMI_INFOFRAME_AUTO_EN
    logic       r_vs_d;
    logic [1:0] r_pend;

    assign w_req = req | {r_pend, 2'b00};

    // Clear on grant first, so a vSync edge in the same cycle re-arms the request.
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d <= 1'b0;
            r_pend <= '0;
        end else begin
            r_vs_d <= vSync;
            r_pend <= (r_pend & ~w_grant_n[3:2]) | {2{vSync & ~r_vs_d}};
        end
    end
`else
    logic w_vsync_unused;
    assign w_vsync_unused = vSync;
    assign w_req = req;
`endif

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_pop = w_pop + {2'b00, w_req[i]};
        end
        w_n_new = (w_pop > 3'(MAX_PACKETS)) ? 2'(MAX_PACKETS) : w_pop[1:0];
    end

    // Fixed priority ACR > audio sample > infoframes; infoframes share a round-robin pointer.
    always_comb begin
        w_arb_grant = '0;
        if (w_req[0])                  w_arb_grant = 4'b0001;
        else if (w_req[1])             w_arb_grant = 4'b0010;
        else if (w_req[2] && w_req[3]) w_arb_grant = r_rr ? 4'b1000 : 4'b0100;
        else if (w_req[2])             w_arb_grant = 4'b0100;
        else if (w_req[3])             w_arb_grant = 4'b1000;
    end

    assign w_more = ({1'b0, r_slot} + 3'd1) < {1'b0, r_n};

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 5'd1;
        w_slot_n  = r_slot;
        w_n_n     = r_n;
        w_arb     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (CounterX == 10'(CTL_END)) begin
                    w_state_n = S_VPRE;
                end else if (CounterX == 10'(DATA_START) && (w_req != '0)) begin
                    w_state_n = S_DPRE;
                    w_n_n     = w_n_new;
                    w_slot_n  = '0;
                end
            end
            S_DPRE: if (r_cnt == 5'd7) begin
                w_state_n = S_LGB;
                w_cnt_n   = '0;
            end
            S_LGB: begin
                w_arb = (r_cnt == 5'd0);
                if (r_cnt == 5'd1) begin
                    w_state_n = S_PKT;
                    w_cnt_n   = '0;
                    w_slot_n  = '0;
                end
            end
            S_PKT: begin
                w_arb = (r_cnt == 5'd30) && w_more;
                if (r_cnt == 5'd31) begin
                    if (w_more) begin
                        w_slot_n = r_slot + 2'd1;
                    end else begin
                        w_state_n = S_TGB;
                        w_cnt_n   = '0;
                    end
                end
            end
            S_TGB: if (r_cnt == 5'd1) begin
                w_state_n = S_CTL;
                w_cnt_n   = '0;
            end
            S_CTL: begin
                w_cnt_n = '0;
                if (CounterX == 10'(CTL_END)) w_state_n = S_VPRE;
            end
            S_VPRE: if (r_cnt == 5'd7) begin
                w_state_n = S_VGB;
                w_cnt_n   = '0;
            end
            S_VGB: if (r_cnt == 5'd1) begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
            default: w_state_n = S_IDLE;
        endcase
        w_grant_n = w_arb ? w_arb_grant : '0;
    end

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_slot     <= '0;
            r_n        <= '0;
            r_rr       <= 1'b0;
            grant      <= '0;
            null_slot  <= 1'b0;
            preamble   <= '0;
            terc_data  <= 1'b0;
            data_gb    <= 1'b0;
            video_gb   <= 1'b0;
            pkt_offset <= '0;
            first_pkt  <= 1'b0;
            hdr_ecc_en <= 1'b0;
            sub_ecc_en <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_slot  <= w_slot_n;
            r_n     <= w_n_n;
            if (w_grant_n[2])      r_rr <= 1'b1;
            else if (w_grant_n[3]) r_rr <= 1'b0;
            grant      <= w_grant_n;
            null_slot  <= w_arb && (w_arb_grant == '0);
            preamble   <= (w_state_n == S_DPRE) ? 4'b0101 :
                          (w_state_n == S_VPRE) ? 4'b0001 : 4'b0000;
            terc_data  <= (w_state_n == S_LGB) || (w_state_n == S_PKT) || (w_state_n == S_TGB);
            data_gb    <= (w_state_n == S_LGB) || (w_state_n == S_TGB);
            video_gb   <= (w_state_n == S_VGB);
            pkt_offset <= (w_state_n == S_PKT) ? w_cnt_n : 5'd0;
            first_pkt  <= (w_state_n == S_PKT) && (w_slot_n == 2'd0);
            hdr_ecc_en <= (w_state_n == S_PKT) && (w_cnt_n < 5'd24);
            sub_ecc_en <= (w_state_n == S_PKT) && (w_cnt_n < 5'd28);
        end
    end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Self-checking bench for hdmi_island_scheduler: line-timeline reference model, directed and random requests.
// Build with HDMI_INFOFRAME_AUTO_EN to exercise the automatic infoframe path.
module tb_hdmi_island_scheduler;

    localparam int DS   = 724;
    localparam int CE   = 848;
    localparam int FW   = 858;
    localparam int MAXP = 2;
`ifdef HDMI_INFOFRAME_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       pixclk = 1'b0;
    logic       reset_n;
    logic [9:0] CounterX;
    logic       vSync;
    logic [3:0] req;
    logic [3:0] grant;
    logic       null_slot;
    logic [3:0] preamble;
    logic       terc_data, data_gb, video_gb;
    logic [4:0] pkt_offset;
    logic       first_pkt, hdr_ecc_en, sub_ecc_en;

    hdmi_island_scheduler #(
        .DISPLAY_WIDTH(720),
        .FULL_WIDTH   (858),
        .MAX_PACKETS  (MAXP)
    ) dut (
        .pixclk    (pixclk),
        .reset_n   (reset_n),
        .CounterX  (CounterX),
        .vSync     (vSync),
        .req       (req),
        .grant     (grant),
        .null_slot (null_slot),
        .preamble  (preamble),
        .terc_data (terc_data),
        .data_gb   (data_gb),
        .video_gb  (video_gb),
        .pkt_offset(pkt_offset),
        .first_pkt (first_pkt),
        .hdr_ecc_en(hdr_ecc_en),
        .sub_ecc_en(sub_ecc_en)
    );

    always #5 pixclk = ~pixclk;

    int n_assert = 0;
    int n_fail   = 0;
    int x        = 0;
    logic [3:0] src = '0;

    // Reference model: a line timeline. mode 0 idle, 1 island (index from DATA_START),
    // 2 control wait, 3 video prefix (index from CTL_END).
    int         m_mode = 0;
    int         m_idx  = 0;
    int         m_n    = 0;
    bit         m_rr   = 1'b0;
    logic [1:0] m_pend = '0;
    logic       m_vs   = 1'b0;
    logic [3:0] e_grant = '0;
    logic       e_null  = 1'b0;

    function automatic logic [3:0] pick(input logic [3:0] r, input bit rr);
        if (r[0]) return 4'b0001;
        if (r[1]) return 4'b0010;
        if (r[2] && r[3]) return rr ? 4'b1000 : 4'b0100;
        if (r[2]) return 4'b0100;
        if (r[3]) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic model_edge();
        logic [3:0] wr;
        int pop;
        e_grant = '0;
        e_null  = 1'b0;
        if (!reset_n) begin
            m_mode = 0; m_idx = 0; m_n = 0; m_rr = 1'b0; m_pend = '0; m_vs = 1'b0;
            return;
        end
        wr  = req | (AUTO ? {m_pend, 2'b00} : 4'b0000);
        pop = $countones(wr);
        case (m_mode)
            0: begin
                if (int'(CounterX) == CE) begin
                    m_mode = 3; m_idx = 0;
                end else if (int'(CounterX) == DS && wr != 0) begin
                    m_mode = 1; m_idx = 0; m_n = (pop > MAXP) ? MAXP : pop;
                end
            end
            1: begin
                m_idx++;
                if (m_idx == 12 + 32 * m_n) begin
                    m_mode = 2;
                end else if (m_idx >= 9 && (m_idx - 9) % 32 == 0 && (m_idx - 9) / 32 < m_n) begin
                    e_grant = pick(wr, m_rr);
                    e_null  = (e_grant == 0);
                    if (e_grant[2]) m_rr = 1'b1;
                    if (e_grant[3]) m_rr = 1'b0;
                    if (AUTO) m_pend = m_pend & ~e_grant[3:2];
                end
            end
            2: if (int'(CounterX) == CE) begin
                m_mode = 3; m_idx = 0;
            end
            default: begin
                m_idx++;
                if (m_idx == 10) m_mode = 0;
            end
        endcase
        if (AUTO) m_pend = m_pend | {2{vSync & ~m_vs}};
        m_vs = vSync;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at x=%0d observed=%0h expected=%0h", tag, x, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit isl, pkt;
        int off;
        isl = (m_mode == 1);
        pkt = isl && m_idx >= 10 && m_idx < 10 + 32 * m_n;
        off = pkt ? (m_idx - 10) % 32 : 0;
        chk("grant", 32'(grant), 32'(e_grant));
        chk("null_slot", 32'(null_slot), 32'(e_null));
        chk("preamble", 32'(preamble),
            (isl && m_idx < 8) ? 32'h5 : (m_mode == 3 && m_idx < 8) ? 32'h1 : 32'h0);
        chk("terc_data", 32'(terc_data), 32'(isl && m_idx >= 8));
        chk("data_gb", 32'(data_gb), 32'(isl && (m_idx == 8 || m_idx == 9 || m_idx >= 10 + 32 * m_n)));
        chk("video_gb", 32'(video_gb), 32'(m_mode == 3 && m_idx >= 8));
        chk("pkt_offset", 32'(pkt_offset), 32'(off));
        chk("first_pkt", 32'(first_pkt), 32'(pkt && (m_idx - 10) / 32 == 0));
        chk("hdr_ecc_en", 32'(hdr_ecc_en), 32'(pkt && off < 24));
        chk("sub_ecc_en", 32'(sub_ecc_en), 32'(pkt && off < 28));
    endtask

    // One pixel: drive, clock, model, sample on the falling edge, then sources drop what was granted.
    task automatic tick();
        CounterX = 10'(x);
        req      = src;
        @(posedge pixclk);
        model_edge();
        @(negedge pixclk);
        check_outputs();
        src = src & ~grant;
        x = (x + 1) % FW;
    endtask

    task automatic run_to(input int target);
        while (x != target) tick();
    endtask

    task automatic run_line();
        do tick(); while (x != 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        vSync    = 1'b0;
        CounterX = '0;
        req      = '0;
        repeat (3) tick();
        reset_n = 1'b1;

        // No request at DATA_START: only the video prefix appears.
        run_to(0);

        // Single audio-sample request.
        run_to(700); src = 4'b0010; run_to(0);

        // All four: ACR then audio sample; next line infoframes AVI then audio.
        run_to(700); src = 4'b1111; run_to(0);
        run_line();

        // Audio sample withdrawn before the slot-1 boundary: null slot.
        run_to(700); src = 4'b0011; run_to(DS + 20); src[1] = 1'b0; run_to(0);

        // Random arrivals, including mid-island.
        for (int l = 0; l < 4; l++) begin
            do begin
                if ($urandom_range(0, 149) == 0) src = src | 4'(1 << $urandom_range(0, 3));
                tick();
            end while (x != 0);
        end
        src = '0;
        run_line();

        // Asynchronous reset mid-packet, released past DATA_START.
        run_to(700); src = 4'b0011; run_to(DS + 15);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_terc", 32'(terc_data), 32'h0);
        chk("rst_pkt_offset", 32'(pkt_offset), 32'h0);
        chk("rst_first_pkt", 32'(first_pkt), 32'h0);
        chk("rst_hdr", 32'(hdr_ecc_en), 32'h0);
        chk("rst_sub", 32'(sub_ecc_en), 32'h0);
        chk("rst_preamble", 32'(preamble), 32'h0);
        chk("rst_null", 32'(null_slot), 32'h0);
        while (x != 730) tick();
        reset_n = 1'b1;
        run_to(0);
        run_line();
        src = '0;
        run_line();

        // vSync edge with no external requests.
        run_to(100); vSync = 1'b1;
        repeat (3) tick();
        vSync = 1'b0;
        run_to(0);
        run_line();
        run_line();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
